stream_rr_merge: RTL and testbench

- Two-input round-robin arbiter that shares one downstream stream consumer (e.g. an ap-style stream primitive) between two stream producers.
- Each input uses the codebase stream convention: data, `_valid`, `_ready`. The single output stream is registered and carries a source tag.
- A burst limit keeps a streaming producer from starving the other, while still allowing back-to-back transfers from one source.

---
 rtl/stream_rr_merge.sv | 65 ++++++
 tb/tb_stream_rr_merge.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/stream_rr_merge.sv
// stream_rr_merge: two-input round-robin stream merge with burst limit and registered, source-tagged output
module stream_rr_merge #(
  parameter int N     = 8,
  parameter int BURST = 4,
  parameter int CW    = 3
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [N-1:0] in0,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [N-1:0] in1,
  input  logic         in1_valid,
  output logic         in1_ready,
  output logic [N-1:0] out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_src,
  output logic         grant
);
  logic [N-1:0]  out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic          out_src_q, out_src_d;
  logic          grant_q, grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load, v_own, v_oth, sw, sel, v_sel, xfer;
  always_comb begin
    load        = !out_valid_q | out_ready;
    v_own       = grant_q ? in1_valid : in0_valid;
    v_oth       = grant_q ? in0_valid : in1_valid;
    sw          = v_oth & (!v_own | (cnt_q == CW'(BURST)));
    sel         = sw ? !grant_q : grant_q;
    v_sel       = sel ? in1_valid : in0_valid;
    xfer        = load & v_sel;
    // readies are gated by nrst so nothing is accepted while reset is held
    in0_ready   = nrst & load & !sel;
    in1_ready   = nrst & load & sel;
    out_d       = xfer ? (sel ? in1 : in0) : out_q;
    out_src_d   = xfer ? sel : out_src_q;
    out_valid_d = load ? xfer : out_valid_q;
    grant_d     = xfer ? sel : grant_q;
    cnt_d       = !xfer ? cnt_q :
                  (sel != grant_q) ? CW'(1) :
                  (cnt_q == CW'(BURST)) ? cnt_q : cnt_q + CW'(1);
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= 1'b0;
      grant_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
    end
  end
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;
  assign grant     = grant_q;
endmodule

// File: tb/tb_stream_rr_merge.sv
// tb_stream_rr_merge: directed checks of the round-robin merge against hand-computed sequences
module tb_stream_rr_merge;
  logic       clk = 1'b0, nrst = 1'b0;
  logic [7:0] in0 = '0, in1 = '0, out;
  logic       in0_valid = 1'b0, in1_valid = 1'b0, out_ready = 1'b1;
  logic       in0_ready, in1_ready, out_valid, out_src, grant;
  logic [7:0] base0 = '0, base1 = '0;
  int         k0 = 0, k1 = 0, checks = 0, errors = 0;
  logic       r0, r1;
  logic [7:0] exp_seq [17] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23,
                               8'h14, 8'h15, 8'h16, 8'h17, 8'h24, 8'h25, 8'h26, 8'h27, 8'h18};

  stream_rr_merge #(.N(8), .BURST(4), .CW(3)) dut (
    .clk(clk), .nrst(nrst),
    .in0(in0), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1(in1), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // one cycle: present the next element of each source, capture readies, advance past the edge
  task automatic step(input logic v0, input logic v1, input logic rdy);
    in0 = base0 + 8'(k0);
    in1 = base1 + 8'(k1);
    in0_valid = v0;
    in1_valid = v1;
    out_ready = rdy;
    #1;
    r0 = in0_ready;
    r1 = in1_ready;
    @(posedge clk);
    #1;
    if (r0 && v0) k0++;
    if (r1 && v1) k1++;
  endtask

  task automatic do_reset;
    nrst = 1'b0;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    k0 = 0;
    k1 = 0;
  endtask

  initial begin
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_src", out_src, 0);
    chk("rst_grant", grant, 0);
    chk("rst_rdy0", in0_ready, 0);
    chk("rst_rdy1", in1_ready, 0);
    nrst = 1'b1;
    base0 = 8'h01;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("single_out", out, i + 1);
      chk("single_valid", out_valid, 1);
      chk("single_src", out_src, 0);
      chk("single_r0", r0, 1);
      chk("single_r1", r1, 0);
    end
    chk("sat_cnt", dut.cnt_q, 4);
    step(1'b0, 1'b0, 1'b1);
    chk("drain_valid", out_valid, 0);

    do_reset();
    base0 = 8'h10;
    base1 = 8'h20;
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 1'b1, 1'b1);
      chk("rr_out", out, exp_seq[i]);
      chk("rr_src", out_src, exp_seq[i][5]);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk("stall_out", out, 8'h25);
      chk("stall_src", out_src, 1);
      chk("stall_valid", out_valid, 1);
      chk("stall_r0", r0, 0);
      chk("stall_r1", r1, 0);
      chk("stall_cnt", dut.cnt_q, 2);
    end
    for (int i = 14; i < 17; i++) begin
      step(1'b1, 1'b1, 1'b1);
      chk("resume_out", out, exp_seq[i]);
      chk("resume_src", out_src, exp_seq[i][5]);
    end

    do_reset();
    base0 = 8'h30;
    base1 = 8'h40;
    step(1'b1, 1'b1, 1'b1);
    chk("hand_out0", out, 8'h30);
    step(1'b1, 1'b1, 1'b1);
    chk("hand_out1", out, 8'h31);
    step(1'b0, 1'b1, 1'b1);
    chk("hand_out2", out, 8'h40);
    chk("hand_valid", out_valid, 1);
    chk("hand_src", out_src, 1);
    chk("hand_grant", grant, 1);
    chk("hand_cnt", dut.cnt_q, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1);
      chk("idle_valid", out_valid, 0);
    end
    chk("idle_grant", grant, 1);
    chk("idle_cnt", dut.cnt_q, 1);
    step(1'b0, 1'b1, 1'b1);
    chk("restart_r1", r1, 1);
    chk("restart_out", out, 8'h41);
    chk("restart_valid", out_valid, 1);

    step(1'b1, 1'b1, 1'b1);
    chk("pre_ar_valid", out_valid, 1);
    chk("pre_ar_grant", grant, 1);
    #2;
    nrst = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_grant", grant, 0);
    chk("ar_cnt", dut.cnt_q, 0);
    chk("ar_out", out, 0);
    chk("ar_r0", in0_ready, 0);
    chk("ar_r1", in1_ready, 0);
    #1;
    nrst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    chk("post_ar_src", out_src, 0);
    chk("post_ar_out", out, 8'h32);
    chk("post_ar_grant", grant, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
